// File: rtl/tlb_pkg.sv
// rtl/tlb_pkg.sv - field widths, entry layout and sweep states for the pipelined TLB
package tlb_pkg;

   localparam int VPN2_W = 19;
   localparam int ASID_W = 8;
   localparam int PFN_W  = 20;
   localparam int C_W    = 3;

   typedef struct packed {
      logic [VPN2_W-1:0] vpn2;
      logic [ASID_W-1:0] asid;
      logic              g;
      logic [PFN_W-1:0]  pfn0;
      logic [C_W-1:0]    c0;
      logic              d0;
      logic              v0;
      logic [PFN_W-1:0]  pfn1;
      logic [C_W-1:0]    c1;
      logic              d1;
      logic              v1;
   } tlb_entry_t;

   typedef enum logic {
      SW_IDLE,
      SW_SWEEP
   } sweep_state_t;

endpackage

// File: rtl/tlb_match.sv
// rtl/tlb_match.sv - one registered search port: match, lowest-index priority, page select
// Multi-hit detection exists only when TLB_MULTI_HIT_EN is defined.
module tlb_match
   import tlb_pkg::*;
#(
   parameter int  TLBNUM = 16,
   localparam int IW     = $clog2(TLBNUM)
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  tlb_entry_t [TLBNUM-1:0] entries,
   input  logic                    req,
   input  logic [VPN2_W-1:0]       vpn2,
   input  logic                    odd,
   input  logic [ASID_W-1:0]       asid,
   output logic                    rvalid,
   output logic                    found,
   output logic                    multi,
   output logic [IW-1:0]           index,
   output logic [PFN_W-1:0]        pfn,
   output logic [C_W-1:0]          c,
   output logic                    d,
   output logic                    v
);

   logic [TLBNUM-1:0] match;
   logic              hit;
   logic [IW-1:0]     hit_idx;
   tlb_entry_t        sel;
   logic              multi_n;

   always_comb begin
      match = '0;
      for (int i = 0; i < TLBNUM; i++)
         match[i] = (entries[i].vpn2 == vpn2) && ((entries[i].asid == asid) || entries[i].g);
   end

   // Descending scan so the lowest matching index is the one left standing.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = TLBNUM - 1; i >= 0; i--) begin
         if (match[i]) begin
            hit     = 1'b1;
            hit_idx = IW'(i);
         end
      end
   end

   assign sel = entries[hit_idx];

`ifdef TLB_MULTI_HIT_EN
   assign multi_n = ($countones(match) > 1);
`else
   assign multi_n = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!resetn) begin
         rvalid <= 1'b0;
         found  <= 1'b0;
         multi  <= 1'b0;
         index  <= '0;
         pfn    <= '0;
         c      <= '0;
         d      <= 1'b0;
         v      <= 1'b0;
      end else begin
         rvalid <= req;
         if (req) begin
            found <= hit;
            multi <= multi_n;
            index <= hit_idx;
            pfn   <= !hit ? '0   : (odd ? sel.pfn1 : sel.pfn0);
            c     <= !hit ? '0   : (odd ? sel.c1   : sel.c0);
            d     <= !hit ? 1'b0 : (odd ? sel.d1   : sel.d0);
            v     <= !hit ? 1'b0 : (odd ? sel.v1   : sel.v0);
         end
      end
   end

endmodule

// File: rtl/tlb_pipe.sv
// rtl/tlb_pipe.sv - pipelined TLB: NPORT search ports, read port, random-index write, invalidation sweep
// Optional multi-hit reporting under TLB_MULTI_HIT_EN.
module tlb_pipe
   import tlb_pkg::*;
#(
   parameter int  TLBNUM = 16,
   parameter int  NPORT  = 2,
   localparam int IW     = $clog2(TLBNUM)
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic [NPORT-1:0]          s_req,
   input  logic [NPORT*VPN2_W-1:0]   s_vpn2,
   input  logic [NPORT-1:0]          s_odd,
   input  logic [NPORT*ASID_W-1:0]   s_asid,
   output logic [NPORT-1:0]          s_rvalid,
   output logic [NPORT-1:0]          s_found,
   output logic [NPORT-1:0]          s_multi,
   output logic [NPORT*IW-1:0]       s_index,
   output logic [NPORT*PFN_W-1:0]    s_pfn,
   output logic [NPORT*C_W-1:0]      s_c,
   output logic [NPORT-1:0]          s_d,
   output logic [NPORT-1:0]          s_v,
   input  logic                      we,
   input  logic                      w_random,
   input  logic [IW-1:0]             w_index,
   input  logic [VPN2_W-1:0]         w_vpn2,
   input  logic [ASID_W-1:0]         w_asid,
   input  logic                      w_g,
   input  logic [PFN_W-1:0]          w_pfn0,
   input  logic [C_W-1:0]            w_c0,
   input  logic                      w_d0,
   input  logic                      w_v0,
   input  logic [PFN_W-1:0]          w_pfn1,
   input  logic [C_W-1:0]            w_c1,
   input  logic                      w_d1,
   input  logic                      w_v1,
   input  logic [IW-1:0]             wired,
   output logic [IW-1:0]             random,
   input  logic                      r_req,
   input  logic [IW-1:0]             r_index,
   output logic                      r_valid,
   output logic [VPN2_W-1:0]         r_vpn2,
   output logic [ASID_W-1:0]         r_asid,
   output logic                      r_g,
   output logic [PFN_W-1:0]          r_pfn0,
   output logic [C_W-1:0]            r_c0,
   output logic                      r_d0,
   output logic                      r_v0,
   output logic [PFN_W-1:0]          r_pfn1,
   output logic [C_W-1:0]            r_c1,
   output logic                      r_d1,
   output logic                      r_v1,
   input  logic                      inv_req,
   input  logic                      inv_all,
   input  logic [ASID_W-1:0]         inv_asid,
   output logic                      inv_busy
);

   tlb_entry_t [TLBNUM-1:0] tlb_q;
   tlb_entry_t              w_entry;
   tlb_entry_t              r_entry_q;
   logic [IW-1:0]           random_q;
   logic [IW-1:0]           w_idx;
   sweep_state_t            sw_state, sw_next;
   logic [IW-1:0]           sw_cnt;
   logic [ASID_W-1:0]       sw_asid;
   logic                    sw_all;
   logic                    sw_clear;

   assign w_entry = '{vpn2: w_vpn2, asid: w_asid, g: w_g,
                      pfn0: w_pfn0, c0: w_c0, d0: w_d0, v0: w_v0,
                      pfn1: w_pfn1, c1: w_c1, d1: w_d1, v1: w_v1};
   assign w_idx    = w_random ? random_q : w_index;
   assign sw_clear = (sw_state == SW_SWEEP) &&
                     (sw_all || (!tlb_q[sw_cnt].g && (tlb_q[sw_cnt].asid == sw_asid)));

   // Only the valid bits are reset; the write is applied after the sweep clear so it wins.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < TLBNUM; i++) begin
            tlb_q[i].v0 <= 1'b0;
            tlb_q[i].v1 <= 1'b0;
         end
      end else begin
         if (sw_clear) begin
            tlb_q[sw_cnt].v0 <= 1'b0;
            tlb_q[sw_cnt].v1 <= 1'b0;
         end
         if (we)
            tlb_q[w_idx] <= w_entry;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn)
         random_q <= IW'(TLBNUM - 1);
      else
         random_q <= (random_q <= wired) ? IW'(TLBNUM - 1) : random_q - 1'b1;
   end

   assign random = random_q;

   always_comb begin
      sw_next = sw_state;
      case (sw_state)
         SW_IDLE:  if (inv_req) sw_next = SW_SWEEP;
         SW_SWEEP: if (sw_cnt == IW'(TLBNUM - 1)) sw_next = SW_IDLE;
         default:  sw_next = SW_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         sw_state <= SW_IDLE;
         sw_cnt   <= '0;
         sw_asid  <= '0;
         sw_all   <= 1'b0;
      end else begin
         sw_state <= sw_next;
         if (sw_state == SW_IDLE && inv_req) begin
            sw_cnt  <= '0;
            sw_asid <= inv_asid;
            sw_all  <= inv_all;
         end else if (sw_state == SW_SWEEP) begin
            sw_cnt <= sw_cnt + 1'b1;
         end
      end
   end

   assign inv_busy = (sw_state == SW_SWEEP);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_valid   <= 1'b0;
         r_entry_q <= '0;
      end else begin
         r_valid <= r_req;
         if (r_req)
            r_entry_q <= tlb_q[r_index];
      end
   end

   assign r_vpn2 = r_entry_q.vpn2;
   assign r_asid = r_entry_q.asid;
   assign r_g    = r_entry_q.g;
   assign r_pfn0 = r_entry_q.pfn0;
   assign r_c0   = r_entry_q.c0;
   assign r_d0   = r_entry_q.d0;
   assign r_v0   = r_entry_q.v0;
   assign r_pfn1 = r_entry_q.pfn1;
   assign r_c1   = r_entry_q.c1;
   assign r_d1   = r_entry_q.d1;
   assign r_v1   = r_entry_q.v1;

   for (genvar p = 0; p < NPORT; p++) begin : g_port
      tlb_match #(.TLBNUM(TLBNUM)) u_match (
         .clk    (clk),
         .resetn (resetn),
         .entries(tlb_q),
         .req    (s_req[p]),
         .vpn2   (s_vpn2[p*VPN2_W +: VPN2_W]),
         .odd    (s_odd[p]),
         .asid   (s_asid[p*ASID_W +: ASID_W]),
         .rvalid (s_rvalid[p]),
         .found  (s_found[p]),
         .multi  (s_multi[p]),
         .index  (s_index[p*IW +: IW]),
         .pfn    (s_pfn[p*PFN_W +: PFN_W]),
         .c      (s_c[p*C_W +: C_W]),
         .d      (s_d[p]),
         .v      (s_v[p])
      );
   end

endmodule

// File: tb/tb_tlb_pipe.sv
// tb/tb_tlb_pipe.sv - scoreboard bench for tlb_pipe (TLBNUM=16, NPORT=2)
module tb_tlb_pipe;
   import tlb_pkg::*;

   localparam int TLBNUM = 16;
   localparam int NPORT  = 2;
   localparam int IW     = 4;
`ifdef TLB_MULTI_HIT_EN
   localparam logic MULTI_EXP = 1'b1;
`else
   localparam logic MULTI_EXP = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                    resetn;
   logic [NPORT-1:0]        s_req, s_odd, s_rvalid, s_found, s_multi, s_d, s_v;
   logic [NPORT*VPN2_W-1:0] s_vpn2;
   logic [NPORT*ASID_W-1:0] s_asid;
   logic [NPORT*IW-1:0]     s_index;
   logic [NPORT*PFN_W-1:0]  s_pfn;
   logic [NPORT*C_W-1:0]    s_c;
   logic we, w_random, w_g, w_d0, w_v0, w_d1, w_v1;
   logic [IW-1:0]     w_index, wired, random, r_index;
   logic [VPN2_W-1:0] w_vpn2, r_vpn2;
   logic [ASID_W-1:0] w_asid, r_asid, inv_asid;
   logic [PFN_W-1:0]  w_pfn0, w_pfn1, r_pfn0, r_pfn1;
   logic [C_W-1:0]    w_c0, w_c1, r_c0, r_c1;
   logic r_req, r_valid, r_g, r_d0, r_v0, r_d1, r_v1;
   logic inv_req, inv_all, inv_busy;

   tlb_pipe #(.TLBNUM(TLBNUM), .NPORT(NPORT)) dut (
      .clk(clk), .resetn(resetn),
      .s_req(s_req), .s_vpn2(s_vpn2), .s_odd(s_odd), .s_asid(s_asid),
      .s_rvalid(s_rvalid), .s_found(s_found), .s_multi(s_multi), .s_index(s_index),
      .s_pfn(s_pfn), .s_c(s_c), .s_d(s_d), .s_v(s_v),
      .we(we), .w_random(w_random), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid),
      .w_g(w_g), .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
      .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
      .wired(wired), .random(random),
      .r_req(r_req), .r_index(r_index), .r_valid(r_valid),
      .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g), .r_pfn0(r_pfn0), .r_c0(r_c0),
      .r_d0(r_d0), .r_v0(r_v0), .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1),
      .inv_req(inv_req), .inv_all(inv_all), .inv_asid(inv_asid), .inv_busy(inv_busy)
   );

   typedef struct packed {
      logic             found;
      logic             multi;
      logic [IW-1:0]    index;
      logic [PFN_W-1:0] pfn;
      logic [C_W-1:0]   c;
      logic             d;
      logic             v;
   } sres_t;

   typedef struct packed {
      tlb_entry_t e;
      tlb_entry_t m;
   } rexp_t;

   sres_t      sq0[$];
   sres_t      sq1[$];
   rexp_t      rq[$];
   tlb_entry_t shadow [TLBNUM];
   int         checks = 0;
   int         errors = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic tlb_entry_t mk(input logic [VPN2_W-1:0] vpn2, input logic [ASID_W-1:0] asid,
                                     input logic g, input logic [PFN_W-1:0] pfn0, input logic [C_W-1:0] c0,
                                     input logic d0, input logic v0, input logic [PFN_W-1:0] pfn1,
                                     input logic [C_W-1:0] c1, input logic d1, input logic v1);
      tlb_entry_t e;
      e = '{vpn2: vpn2, asid: asid, g: g, pfn0: pfn0, c0: c0, d0: d0, v0: v0,
            pfn1: pfn1, c1: c1, d1: d1, v1: v1};
      return e;
   endfunction

   function automatic tlb_entry_t base(input int i);
      return mk(19'h70000 | 19'(i), 8'hF0, 1'b0, 20'(i), 3'd0, 1'b0, 1'b0,
                20'h100 + 20'(i), 3'd0, 1'b0, 1'b0);
   endfunction

   function automatic sres_t hit(input int idx, input tlb_entry_t e, input logic odd, input logic multi);
      sres_t r;
      r.found = 1'b1;
      r.multi = multi;
      r.index = IW'(idx);
      r.pfn   = odd ? e.pfn1 : e.pfn0;
      r.c     = odd ? e.c1 : e.c0;
      r.d     = odd ? e.d1 : e.d0;
      r.v     = odd ? e.v1 : e.v0;
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      we = 1'b0; w_random = 1'b0; s_req = '0; r_req = 1'b0; inv_req = 1'b0;
   endtask

   task automatic write_e(input int idx, input tlb_entry_t e, input logic rnd);
      we = 1'b1; w_random = rnd; w_index = rnd ? 4'd0 : IW'(idx);
      w_vpn2 = e.vpn2; w_asid = e.asid; w_g = e.g;
      w_pfn0 = e.pfn0; w_c0 = e.c0; w_d0 = e.d0; w_v0 = e.v0;
      w_pfn1 = e.pfn1; w_c1 = e.c1; w_d1 = e.d1; w_v1 = e.v1;
      shadow[idx] = e;
   endtask

   task automatic search(input int p, input logic [VPN2_W-1:0] vpn2, input logic odd,
                         input logic [ASID_W-1:0] asid, input sres_t exp);
      s_req[p] = 1'b1;
      s_odd[p] = odd;
      s_vpn2[p*VPN2_W +: VPN2_W] = vpn2;
      s_asid[p*ASID_W +: ASID_W] = asid;
      if (p == 0) sq0.push_back(exp);
      else        sq1.push_back(exp);
   endtask

   task automatic read(input int idx);
      rexp_t x;
      r_req = 1'b1;
      r_index = IW'(idx);
      x.e = shadow[idx];
      x.m = '1;
      rq.push_back(x);
   endtask

   // Monitor: pops and compares whenever a result is presented.
   initial begin
      sres_t act, e;
      rexp_t rx;
      tlb_entry_t ract;
      forever begin
         @(negedge clk);
         for (int p = 0; p < NPORT; p++) begin
            if (s_rvalid[p]) begin
               act = '{found: s_found[p], multi: s_multi[p], index: s_index[p*IW +: IW],
                       pfn: s_pfn[p*PFN_W +: PFN_W], c: s_c[p*C_W +: C_W], d: s_d[p], v: s_v[p]};
               if ((p == 0 ? sq0.size() : sq1.size()) == 0) begin
                  check($sformatf("unexpected s_rvalid p%0d", p), 1, 0);
               end else begin
                  e = (p == 0) ? sq0.pop_front() : sq1.pop_front();
                  check($sformatf("search result p%0d", p), act, e);
               end
            end
         end
         if (r_valid) begin
            ract = mk(r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1);
            if (rq.size() == 0) begin
               check("unexpected r_valid", 1, 0);
            end else begin
               rx = rq.pop_front();
               check("read entry", ract & rx.m, rx.e & rx.m);
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int rseq [7] = '{14, 13, 12, 15, 14, 13, 12};
      int busy_cnt;
      logic seen, done;
      tlb_entry_t e3, e2, e2w, e9, e6, e4, e11, e13;
      rexp_t rx;

      resetn = 1'b0; s_req = '0; s_odd = '0; s_vpn2 = '0; s_asid = '0;
      we = 1'b0; w_random = 1'b0; w_index = '0; w_vpn2 = '0; w_asid = '0; w_g = 1'b0;
      w_pfn0 = '0; w_c0 = '0; w_d0 = 1'b0; w_v0 = 1'b0; w_pfn1 = '0; w_c1 = '0; w_d1 = 1'b0; w_v1 = 1'b0;
      wired = '0; r_req = 1'b0; r_index = '0; inv_req = 1'b0; inv_all = 1'b0; inv_asid = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset s_rvalid", s_rvalid, 0);
      check("reset s_found", s_found, 0);
      check("reset s_multi", s_multi, 0);
      check("reset s_index", s_index, 0);
      check("reset s_pfn", s_pfn, 0);
      check("reset r_valid", r_valid, 0);
      check("reset r_fields", {r_vpn2, r_asid, r_pfn0, r_pfn1, r_v0, r_v1}, 0);
      check("reset inv_busy", inv_busy, 0);
      check("reset random", random, 15);
      resetn = 1'b1;

      // First searches after reset miss; valid bits of entry 0 are cleared.
      step();
      search(0, 19'h7FFFF, 1'b0, 8'hAA, '0);
      search(1, 19'h7FFFE, 1'b1, 8'h55, '0);
      r_req = 1'b1; r_index = 4'd0;
      rx.e = '0; rx.m = '0; rx.m.v0 = 1'b1; rx.m.v1 = 1'b1;
      rq.push_back(rx);

      for (int i = 0; i < TLBNUM; i++) begin
         step();
         write_e(i, base(i), 1'b0);
      end

      // Write entry 3; same-cycle search sees old contents, next cycle new.
      e3 = mk(19'h12345, 8'h05, 1'b0, 20'h11111, 3'd2, 1'b0, 1'b0, 20'hABCDE, 3'd3, 1'b1, 1'b1);
      step();
      search(0, 19'h12345, 1'b1, 8'h05, '0);
      search(1, 19'h70003, 1'b0, 8'hF0, hit(3, base(3), 1'b0, 1'b0));
      write_e(3, e3, 1'b0);
      step();
      search(0, 19'h12345, 1'b1, 8'h05, hit(3, e3, 1'b1, 1'b0));
      search(1, 19'h12345, 1'b1, 8'h06, '0);
      step();
      search(1, 19'h12345, 1'b0, 8'h05, hit(3, e3, 1'b0, 1'b0));
      step();
      check("hold s_rvalid p0", s_rvalid[0], 0);
      check("hold s_index p0", s_index[IW-1:0], 3);
      check("hold s_pfn p0", s_pfn[PFN_W-1:0], 20'hABCDE);

      // Random: below-wired reload, then the wired=12 cycle.
      wired = 4'd0;
      for (int n = 0; n < 40 && random != 4'd5; n++) step();
      check("random reaches 5", random, 5);
      wired = 4'd12;
      step();
      check("random reload below wired", random, 15);
      for (int k = 0; k < 7; k++) begin
         step();
         check($sformatf("random seq %0d", k), random, rseq[k]);
      end
      step(); step(); step();
      check("random before w_random", random, 13);
      e13 = mk(19'h0ABCD, 8'h13, 1'b0, 20'h13130, 3'd1, 1'b1, 1'b1, 20'h13131, 3'd1, 1'b0, 1'b1);
      write_e(13, e13, 1'b1);
      step();
      read(13);
      step();
      read(0);
      wired = 4'd15;
      step();
      step();
      check("random pinned a", random, 15);
      step();
      check("random pinned b", random, 15);
      wired = 4'd0;

      // ASID sweep with a colliding write on entry 2 and an ignored re-request.
      e2 = mk(19'h00202, 8'h07, 1'b0, 20'h22220, 3'd1, 1'b1, 1'b1, 20'h22221, 3'd1, 1'b1, 1'b1);
      e9 = mk(19'h00909, 8'h07, 1'b1, 20'h99990, 3'd0, 1'b0, 1'b1, 20'h99991, 3'd0, 1'b0, 1'b1);
      e6 = mk(19'h00606, 8'h08, 1'b0, 20'h66660, 3'd0, 1'b0, 1'b1, 20'h66661, 3'd0, 1'b0, 1'b1);
      step(); write_e(2, e2, 1'b0);
      step(); write_e(9, e9, 1'b0);
      step(); write_e(6, e6, 1'b0);
      step(); search(0, 19'h00909, 1'b1, 8'h33, hit(9, e9, 1'b1, 1'b0));
      step(); inv_req = 1'b1; inv_all = 1'b0; inv_asid = 8'h07;
      busy_cnt = 0;
      e2w = mk(19'h00202, 8'h07, 1'b0, 20'h2A2A0, 3'd6, 1'b0, 1'b1, 20'h2A2A1, 3'd6, 1'b0, 1'b0);
      for (int n = 0; n < 60; n++) begin
         step();
         if (inv_busy) busy_cnt++;
         if (inv_busy && busy_cnt == 3) write_e(2, e2w, 1'b0);
         if (inv_busy && busy_cnt == 8) begin inv_req = 1'b1; inv_all = 1'b1; end
         if (!inv_busy && busy_cnt > 0) break;
      end
      inv_all = 1'b0;
      check("sweep busy cycles", busy_cnt, 16);
      read(2);
      step(); read(9);
      step(); read(6);
      step(); read(3);

      // Full sweep clears every valid bit.
      step(); inv_req = 1'b1; inv_all = 1'b1;
      seen = 1'b0; done = 1'b0;
      for (int n = 0; n < 60; n++) begin
         step();
         if (inv_busy) seen = 1'b1;
         if (seen && !inv_busy) begin done = 1'b1; break; end
      end
      inv_all = 1'b0;
      check("sweep all done", done, 1);
      for (int i = 0; i < TLBNUM; i++) begin
         shadow[i].v0 = 1'b0;
         shadow[i].v1 = 1'b0;
      end
      read(9);
      search(0, 19'h00909, 1'b0, 8'h07, hit(9, shadow[9], 1'b0, 1'b0));
      step(); read(13);

      // Duplicate entries: lowest index wins, multi-hit reported only with the macro.
      e4  = mk(19'h05555, 8'h21, 1'b0, 20'h44444, 3'd4, 1'b1, 1'b1, 20'h44445, 3'd0, 1'b0, 1'b1);
      e11 = mk(19'h05555, 8'h21, 1'b0, 20'hBBBBB, 3'd5, 1'b0, 1'b1, 20'hBBBBC, 3'd0, 1'b0, 1'b1);
      step(); write_e(11, e11, 1'b0);
      step(); write_e(4, e4, 1'b0);
      step();
      search(0, 19'h05555, 1'b0, 8'h21, hit(4, e4, 1'b0, MULTI_EXP));
      search(1, 19'h05555, 1'b1, 8'h22, '0);

      repeat (4) step();
      check("search p0 queue drained", sq0.size(), 0);
      check("search p1 queue drained", sq1.size(), 0);
      check("read queue drained", rq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tlb_pipe.md
# tlb_pipe

Parametrised, pipelined successor to the CPU's joint TLB: a TLBNUM-entry MIPS-style TLB with NPORT registered search ports, a registered read port, a write port with hardware random-index selection (TLBWR support), and an ASID/global invalidation sweep engine. It sits between the fetch/memory stages (search), the CP0 logic (TLBP/TLBR/TLBWI/TLBWR) and the exception path, and replaces the single-cycle two-port array.

## Interface
- TLBNUM, 16, entry count; power of two, 4..64; IW = $clog2(TLBNUM)
- NPORT, 2, number of search ports, 1..4
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset; reset is synchronous and active-low on the single clock clk
- s_req  in  NPORT  per-port search request
- s_vpn2 / s_odd / s_asid  in  NPORT*19 / NPORT / NPORT*8  packed per-port lookup key
- s_rvalid  out  NPORT  result valid, one cycle after s_req
- s_found / s_multi  out  NPORT / NPORT  hit; more than one entry matched
- s_index / s_pfn / s_c / s_d / s_v  out  NPORT*IW / NPORT*20 / NPORT*3 / NPORT / NPORT  packed result
- we / w_random  in  1 / 1  write; use random index instead of w_index
- w_index, w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1  in  IW,19,8,1,20,3,1,1,20,3,1,1  entry write data
- wired  in  IW  CP0 Wired; random range lower bound
- random  out  IW  current random index
- r_req / r_index  in  1 / IW  read request
- r_valid  out  1  read data valid, one cycle after r_req
- r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1  out  entry fields
- inv_req / inv_all / inv_asid  in  1 / 1 / 8  start sweep; all entries vs. non-global entries with matching ASID
- inv_busy  out  1  sweep in progress

## Operation
- Match: entry i hits iff vpn2 equal and (asid equal or g). Index = lowest matching i. Page data selected by s_odd.
- Search: key sampled at edge when s_req=1; result registered. s_req=0 -> s_rvalid=0 next cycle, other result regs hold.
- Miss: s_found=0, s_index/s_pfn/s_c/s_d/s_v=0.
- Write: at edge when we=1; index = random if w_random else w_index. All fields written.
- Random: counts down one per cycle; at value == wired, or below wired, next value TLBNUM-1. wired > TLBNUM-1 impossible by width; wired = TLBNUM-1 pins random at TLBNUM-1.
- Sweep FSM: IDLE -> SWEEP on inv_req (ignored while busy); counter 0..TLBNUM-1, one entry per cycle; clears v0 and v1 of entry if inv_all, or if !g and asid == inv_asid latched at start. SWEEP -> IDLE after entry TLBNUM-1.
- Write and sweep same entry same cycle: write wins (entry keeps w_v0/w_v1). Sweep still advances.
- Reset: v0/v1 of every entry cleared; other array fields not reset. Sweep aborted to IDLE.

## Timing
- Search and read latency 1 cycle; fully pipelined, new request every cycle per port.
- No write bypass: search/read sampled in the cycle of a write return pre-write contents; the cycle after, post-write contents.
- Reset values: s_rvalid=0, s_found=0, s_multi=0, s_index/s_pfn/s_c/s_d/s_v=0, r_valid=0, all r_* fields=0, inv_busy=0, random=TLBNUM-1.
- inv_busy rises the cycle after inv_req, falls the cycle after entry TLBNUM-1 is processed (TLBNUM busy cycles).
- random is a register; the value used by a w_random write is the value visible in that cycle.

## Configuration
- TLB_MULTI_HIT_EN defined: s_multi = popcount(match) > 1, registered with the result; CP0 raises machine check on it.
- Undefined: s_multi tied 0, no popcount logic; lowest-index priority unchanged.

## Structure
- Package tlb_pkg: VPN2_W=19, ASID_W=8, PFN_W=20, C_W=3, entry struct (vpn2, asid, g, pfn/c/d/v x2), sweep state enum.
- Sub-module tlb_match: one search port (match vector, priority encode, page select, optional multi-hit), instantiated NPORT times via generate.

## Test plan
- Reset, then search any key on both ports -> s_rvalid=1, s_found=0 next cycle; random=TLBNUM-1.
- Write index 3 {vpn2=0x12345, asid=5, g=0, pfn1=0xABCDE, v1=1}; search vpn2=0x12345 odd=1 asid=5 -> found, index 3, pfn 0xABCDE; asid=6 -> miss.
- Search issued in the same cycle as the write above -> miss; repeated next cycle -> hit.
- wired=12, TLBNUM=16: random sequence ...,13,12,15,14,13,12; w_random write lands at displayed value, confirmed via read port one cycle later.
- Entries 2 (asid 7, g=0) and 9 (asid 7, g=1); inv_req inv_all=0 inv_asid=7 -> inv_busy 16 cycles, entry 2 v0/v1=0, entry 9 unchanged; write to entry 2 during sweep cycle 2 with v0=1 -> v0 stays 1.
- With TLB_MULTI_HIT_EN: identical vpn2/asid in entries 4 and 11 -> index 4, s_multi=1; without macro s_multi=0.
